// File: rtl/req_arbiter_4_pkg.sv
// Shared constants and types for the four-requester arbiter.
package req_arbiter_4_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int NREQ = 4;

    typedef logic [1:0] id_t;

    function automatic logic [NREQ-1:0] onehot(id_t id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/req_arbiter_4_if.sv
// Request/grant bundle between the request sources and the arbiter.
interface req_arbiter_4_if #(
    parameter int CNT_W = 4
);
    import req_arbiter_4_pkg::*;

    logic [NREQ-1:0]  req;
    logic             mode;
    logic [NREQ-1:0]  grant;
    id_t              grant_id;
    logic             grant_valid;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output req, mode,
        input  grant, grant_id, grant_valid, hold_cnt
    );

    modport slave (
        input  req, mode,
        output grant, grant_id, grant_valid, hold_cnt
    );

endinterface

// File: rtl/req_arbiter_4_penc.sv
// Combinational 4-to-2 priority encoder, bit 3 has highest priority.
module priority_encoder_4to2 (
    input  logic [3:0] req_i,
    output logic [1:0] code_o,
    output logic       valid_o
);

    always_comb begin
        code_o = 2'd0;
        priority case (1'b1)
            req_i[3]: code_o = 2'd3;
            req_i[2]: code_o = 2'd2;
            req_i[1]: code_o = 2'd1;
            default:  code_o = 2'd0;
        endcase
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/req_arbiter_4.sv
// Four-requester arbiter: fixed or round-robin, registered grant, bounded hold.
module req_arbiter_4
    import req_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input logic           clk,
    input logic           rst_n,
    req_arbiter_4_if.slave arb
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    id_t              id_q, id_d;
    id_t              last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0]  rot;
    id_t              pcode;
    id_t              win;
    logic             pvalid;

    // Round-robin maps last_id-k to slot k, so the encoder's top slot is last_id+1.
    always_comb begin
        rot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb.mode) rot[k] = arb.req[2'(last_q - 2'(k))];
            else          rot[k] = arb.req[2'(k)];
        end
    end

    priority_encoder_4to2 u_penc (
        .req_i   (rot),
        .code_o  (pcode),
        .valid_o (pvalid)
    );

    assign win = arb.mode ? 2'(last_q - pcode) : pcode;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pvalid) begin
                    state_d = ST_GRANT;
                    grant_d = onehot(win);
                    id_d    = win;
                    last_d  = win;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (!arb.req[id_q] || cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            id_q    <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign arb.grant       = grant_q;
    assign arb.grant_id    = id_q;
    assign arb.grant_valid = state_q;
    assign arb.hold_cnt    = cnt_q;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Directed and random checks of req_arbiter_4 against an ownership model.
module tb_req_arbiter_4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic mode = 1'b0;

    int nchk = 0;
    int nfail = 0;

    int owner[2];
    int cnt[2];
    int last[2];
    int mh[2] = '{8, 2};

    logic [3:0] rr_seq[13] = '{
        4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
        4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1000,
        4'b1000, 4'b0000, 4'b0001
    };

    req_arbiter_4_if #(.CNT_W(4)) ifa ();
    req_arbiter_4_if #(.CNT_W(4)) ifb ();

    assign ifa.req  = req;
    assign ifa.mode = mode;
    assign ifb.req  = req;
    assign ifb.mode = mode;

    req_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (ifa)
    );

    req_arbiter_4 #(.MAX_HOLD(2), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1;
            cnt[m]   = 0;
            last[m]  = 3;
        end
    endtask

    // One clock edge of the ownership rules, in plain arithmetic.
    task automatic mstep(int m);
        int c;
        if (owner[m] < 0) begin
            if (req != 4'b0000) begin
                c = -1;
                if (mode == 1'b0) begin
                    for (int i = 0; i < 4; i++)
                        if (req[i]) c = i;
                end else begin
                    for (int k = 4; k >= 1; k--)
                        if (req[(last[m] + k) % 4]) c = (last[m] + k) % 4;
                end
                owner[m] = c;
                cnt[m]   = 0;
                last[m]  = c;
            end
        end else if (!req[owner[m]] || cnt[m] == mh[m] - 1) begin
            owner[m] = -1;
            cnt[m]   = 0;
        end else begin
            cnt[m]++;
        end
    endtask

    task automatic check_all();
        logic [3:0] g;
        g = (owner[0] < 0) ? 4'b0000 : 4'(1 << owner[0]);
        chk("a_grant", 32'(ifa.grant), 32'(g));
        chk("a_valid", 32'(ifa.grant_valid), 32'(owner[0] >= 0));
        chk("a_cnt", 32'(ifa.hold_cnt), 32'(cnt[0]));
        if (owner[0] >= 0)
            chk("a_id", 32'(ifa.grant_id), 32'(owner[0]));
        g = (owner[1] < 0) ? 4'b0000 : 4'(1 << owner[1]);
        chk("b_grant", 32'(ifb.grant), 32'(g));
        chk("b_valid", 32'(ifb.grant_valid), 32'(owner[1] >= 0));
        chk("b_cnt", 32'(ifb.hold_cnt), 32'(cnt[1]));
        if (owner[1] >= 0)
            chk("b_id", 32'(ifb.grant_id), 32'(owner[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mreset();
        #1;
        check_all();
        chk("rst_id_a", 32'(ifa.grant_id), 32'd0);
        chk("rst_id_b", 32'(ifb.grant_id), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // Fixed priority pick, release, one idle cycle, next grant.
        req = 4'b0101;
        mode = 1'b0;
        tick();
        chk("fix_grant", 32'(ifa.grant), 32'h4);
        chk("fix_id", 32'(ifa.grant_id), 32'd2);
        req = 4'b0001;
        tick();
        chk("rel_gap", 32'(ifa.grant), 32'h0);
        tick();
        chk("rel_next", 32'(ifa.grant), 32'h1);

        // Round-robin rotation with MAX_HOLD=2.
        req = 4'b0000;
        do_reset();
        mode = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk($sformatf("rr_seq%0d", i), 32'(ifb.grant), 32'(rr_seq[i]));
        end

        // Fixed-mode timeout: 8 cycles, one gap, same owner again.
        req = 4'b0000;
        do_reset();
        mode = 1'b0;
        req = 4'b1000;
        for (int i = 0; i < 8; i++) tick();
        chk("to_cnt7", 32'(ifa.hold_cnt), 32'd7);
        tick();
        chk("to_gap", 32'(ifa.grant_valid), 32'd0);
        tick();
        chk("to_again", 32'(ifa.grant_id), 32'd3);

        // Owner drops request early.
        req = 4'b0000;
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 4; i++) tick();
        chk("drop_cnt3", 32'(ifa.hold_cnt), 32'd3);
        req = 4'b0001;
        tick();
        chk("drop_gap", 32'(ifa.grant), 32'h0);
        tick();
        chk("drop_next", 32'(ifa.grant), 32'h1);
        chk("drop_cnt0", 32'(ifa.hold_cnt), 32'd0);

        // Asynchronous reset mid-grant.
        req = 4'b0000;
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_cnt5", 32'(ifa.hold_cnt), 32'd5);
        do_reset();
        mode = 1'b1;
        req = 4'b1001;
        tick();
        chk("post_rst", 32'(ifa.grant), 32'h1);

        // Mode change while granted only affects the next arbitration.
        req = 4'b0000;
        do_reset();
        mode = 1'b0;
        req = 4'b1111;
        tick();
        chk("tog_own", 32'(ifa.grant_id), 32'd3);
        mode = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("tog_rr", 32'(ifa.grant), 32'h1);

        // Random traffic.
        req = 4'b0000;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 99) == 0) do_reset();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
